// File: rtl/min_sec_down_timer_if.sv
// min_sec_down_timer_if: control, preset and display signals of the MM:SS countdown timer
interface min_sec_down_timer_if;
    logic       EN;
    logic       LOAD;
    logic       SS;
    logic [2:0] PMH;
    logic [3:0] PML;
    logic [2:0] PSH;
    logic [3:0] PSL;
    logic [2:0] MH;
    logic [3:0] ML;
    logic [2:0] SH;
    logic [3:0] SL;
    logic       RUNNING;
    logic       TC;
    logic       ALARM;
    modport master (output EN, LOAD, SS, PMH, PML, PSH, PSL,
                    input  MH, ML, SH, SL, RUNNING, TC, ALARM);
    modport slave  (input  EN, LOAD, SS, PMH, PML, PSH, PSL,
                    output MH, ML, SH, SL, RUNNING, TC, ALARM);
endinterface

// File: rtl/min_sec_down_timer.sv
// min_sec_down_timer: BCD MM:SS countdown with start/pause, terminal-count pulse and timed alarm
module min_sec_down_timer #(
    parameter int ALARM_SEC = 10
) (
    input logic CLK,
    input logic RST,
    min_sec_down_timer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
    state_t state_q, state_d;
    logic [2:0] mh_q, mh_d, sh_q, sh_d;
    logic [3:0] ml_q, ml_d, sl_q, sl_d;
    logic [5:0] acnt_q, acnt_d;
    logic       tc_q, tc_d, alarm_q, alarm_d, running_q, running_d;
    logic       zero, last, b_s, b_m, b_mh;
    assign zero = mh_q == 3'd0 && ml_q == 4'd0 && sh_q == 3'd0 && sl_q == 4'd0;
    assign last = mh_q == 3'd0 && ml_q == 4'd0 && sh_q == 3'd0 && sl_q == 4'd1;
    // Borrow chain: each digit borrows only when every lower digit was zero
    assign b_s  = sl_q == 4'd0;
    assign b_m  = b_s && sh_q == 3'd0;
    assign b_mh = b_m && ml_q == 4'd0;
    always_comb begin
        state_d = state_q;
        mh_d    = mh_q;
        ml_d    = ml_q;
        sh_d    = sh_q;
        sl_d    = sl_q;
        acnt_d  = acnt_q;
        alarm_d = alarm_q;
        tc_d    = 1'b0;
        if (bus.LOAD) begin
            mh_d    = bus.PMH > 3'd5 ? 3'd5 : bus.PMH;
            ml_d    = bus.PML > 4'd9 ? 4'd9 : bus.PML;
            sh_d    = bus.PSH > 3'd5 ? 3'd5 : bus.PSH;
            sl_d    = bus.PSL > 4'd9 ? 4'd9 : bus.PSL;
            state_d = IDLE;
            alarm_d = 1'b0;
            acnt_d  = '0;
        end else if (bus.SS) begin
            if (state_q == IDLE && !zero) state_d = RUN;
            else if (state_q == RUN) state_d = PAUSE;
            else if (state_q == PAUSE) state_d = RUN;
            else if (state_q == DONE) begin
                state_d = IDLE;
                alarm_d = 1'b0;
            end
        end else if (bus.EN && state_q == RUN) begin
            sl_d = b_s ? 4'd9 : sl_q - 4'd1;
            sh_d = b_s ? (sh_q == 3'd0 ? 3'd5 : sh_q - 3'd1) : sh_q;
            ml_d = b_m ? (ml_q == 4'd0 ? 4'd9 : ml_q - 4'd1) : ml_q;
            mh_d = b_mh ? mh_q - 3'd1 : mh_q;
            if (last) begin
                state_d = DONE;
                tc_d    = 1'b1;
                alarm_d = 1'b1;
                acnt_d  = '0;
            end
        end else if (bus.EN && state_q == DONE) begin
            acnt_d = acnt_q + 6'd1;
            if (acnt_d == 6'(ALARM_SEC)) begin
                alarm_d = 1'b0;
                state_d = IDLE;
            end
        end
        running_d = state_d == RUN;
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            mh_q      <= '0;
            ml_q      <= '0;
            sh_q      <= '0;
            sl_q      <= '0;
            acnt_q    <= '0;
            tc_q      <= 1'b0;
            alarm_q   <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mh_q      <= mh_d;
            ml_q      <= ml_d;
            sh_q      <= sh_d;
            sl_q      <= sl_d;
            acnt_q    <= acnt_d;
            tc_q      <= tc_d;
            alarm_q   <= alarm_d;
            running_q <= running_d;
        end
    end
    assign bus.MH      = mh_q;
    assign bus.ML      = ml_q;
    assign bus.SH      = sh_q;
    assign bus.SL      = sl_q;
    assign bus.TC      = tc_q;
    assign bus.ALARM   = alarm_q;
    assign bus.RUNNING = running_q;
endmodule

// File: tb/tb_min_sec_down_timer.sv
// tb_min_sec_down_timer: directed countdown, pause, alarm window, clamp and async reset checks
module tb_min_sec_down_timer;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    min_sec_down_timer_if bus ();
    min_sec_down_timer #(.ALARM_SEC(10)) dut (.CLK(CLK), .RST(RST), .bus(bus));
    always #5 CLK = ~CLK;
    function automatic logic [15:0] digits();
        return {1'b0, bus.MH, bus.ML, 1'b0, bus.SH, bus.SL};
    endfunction
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic tick(input logic e, input logic s, input logic l);
        bus.EN = e;
        bus.SS = s;
        bus.LOAD = l;
        @(posedge CLK);
        #1;
        bus.EN = 1'b0;
        bus.SS = 1'b0;
        bus.LOAD = 1'b0;
    endtask
    task automatic preset(input logic [2:0] mh, input logic [3:0] ml, input logic [2:0] sh, input logic [3:0] sl);
        bus.PMH = mh;
        bus.PML = ml;
        bus.PSH = sh;
        bus.PSL = sl;
    endtask
    initial begin
        bus.EN = 1'b0;
        bus.SS = 1'b0;
        bus.LOAD = 1'b0;
        preset(3'd0, 4'd0, 3'd0, 4'd0);
        #2;
        chk("rst_digits", digits(), 16'h0000);
        chk("rst_running", 16'(bus.RUNNING), 16'd0);
        chk("rst_tc", 16'(bus.TC), 16'd0);
        chk("rst_alarm", 16'(bus.ALARM), 16'd0);
        #10 RST = 1'b0;
        // 01:05 countdown across the minute boundary
        preset(3'd0, 4'd1, 3'd0, 4'd5);
        tick(0, 0, 1);
        chk("load_0105", digits(), 16'h0105);
        chk("load_idle", 16'(bus.RUNNING), 16'd0);
        tick(0, 1, 0);
        chk("start_running", 16'(bus.RUNNING), 16'd1);
        for (int i = 0; i < 5; i++) tick(1, 0, 0);
        chk("five_ticks", digits(), 16'h0100);
        tick(1, 0, 0);
        chk("wrap_0059", digits(), 16'h0059);
        // 10:00 borrows through every digit
        preset(3'd1, 4'd0, 3'd0, 4'd0);
        tick(0, 0, 1);
        tick(0, 1, 0);
        tick(1, 0, 0);
        chk("wrap_0959", digits(), 16'h0959);
        // terminal count and alarm window
        preset(3'd0, 4'd0, 3'd0, 4'd2);
        tick(0, 0, 1);
        tick(0, 1, 0);
        tick(1, 0, 0);
        chk("dec_0001", digits(), 16'h0001);
        chk("no_tc_early", 16'(bus.TC), 16'd0);
        tick(1, 0, 0);
        chk("tc_digits", digits(), 16'h0000);
        chk("tc_pulse", 16'(bus.TC), 16'd1);
        chk("tc_alarm", 16'(bus.ALARM), 16'd1);
        chk("tc_not_running", 16'(bus.RUNNING), 16'd0);
        tick(0, 0, 0);
        chk("tc_one_cycle", 16'(bus.TC), 16'd0);
        chk("alarm_hold", 16'(bus.ALARM), 16'd1);
        for (int i = 0; i < 9; i++) tick(1, 0, 0);
        chk("alarm_9_ticks", 16'(bus.ALARM), 16'd1);
        tick(1, 0, 0);
        chk("alarm_10_ticks", 16'(bus.ALARM), 16'd0);
        chk("after_alarm_digits", digits(), 16'h0000);
        tick(0, 1, 0);
        chk("ss_zero_ignored", 16'(bus.RUNNING), 16'd0);
        // pause with coincident EN
        preset(3'd0, 4'd0, 3'd3, 4'd0);
        tick(0, 0, 1);
        tick(0, 1, 0);
        tick(1, 1, 0);
        chk("pause_running", 16'(bus.RUNNING), 16'd0);
        chk("pause_digits", digits(), 16'h0030);
        for (int i = 0; i < 3; i++) tick(1, 0, 0);
        chk("pause_frozen", digits(), 16'h0030);
        tick(0, 1, 0);
        chk("resume_running", 16'(bus.RUNNING), 16'd1);
        tick(1, 0, 0);
        chk("resume_dec", digits(), 16'h0029);
        // out-of-range presets clamp each digit
        preset(3'd6, 4'd15, 3'd7, 4'd12);
        tick(0, 0, 1);
        chk("clamp_5959", digits(), 16'h5959);
        chk("clamp_idle", 16'(bus.RUNNING), 16'd0);
        // SS ends DONE early
        preset(3'd0, 4'd0, 3'd0, 4'd1);
        tick(0, 0, 1);
        tick(0, 1, 0);
        tick(1, 0, 0);
        chk("done_alarm", 16'(bus.ALARM), 16'd1);
        tick(0, 1, 0);
        chk("ss_done_alarm", 16'(bus.ALARM), 16'd0);
        chk("ss_done_idle", 16'(bus.RUNNING), 16'd0);
        chk("ss_done_digits", digits(), 16'h0000);
        // LOAD beats SS and EN during RUN
        preset(3'd0, 4'd0, 3'd1, 4'd0);
        tick(0, 0, 1);
        tick(0, 1, 0);
        preset(3'd0, 4'd2, 3'd0, 4'd0);
        tick(1, 1, 1);
        chk("load_prio_digits", digits(), 16'h0200);
        chk("load_prio_idle", 16'(bus.RUNNING), 16'd0);
        tick(1, 0, 0);
        chk("idle_no_dec", digits(), 16'h0200);
        // asynchronous reset mid-RUN
        preset(3'd1, 4'd2, 3'd3, 4'd5);
        tick(0, 0, 1);
        tick(0, 1, 0);
        tick(1, 0, 0);
        chk("run_1234", digits(), 16'h1234);
        #2 RST = 1'b1;
        #1;
        chk("arst_digits", digits(), 16'h0000);
        chk("arst_running", 16'(bus.RUNNING), 16'd0);
        chk("arst_alarm", 16'(bus.ALARM), 16'd0);
        chk("arst_tc", 16'(bus.TC), 16'd0);
        #2 RST = 1'b0;
        tick(1, 0, 0);
        chk("post_rst_tc", 16'(bus.TC), 16'd0);
        chk("post_rst_digits", digits(), 16'h0000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
